sram_stream_fifo: RTL and testbench

Stream FIFO controller that buffers a valid/ready data stream in an external single-port SRAM macro (the 32x64 ra1shd family) and re-presents it downstream. It sits directly upstream of the macro: it drives A/D/CEN/WEN/OEN and consumes Q. It arbitrates the single port between writes and reads each cycle. A 2-entry output prefetch buffer hides the macro's 1-cycle read latency and its X-on-write Q behaviour from the consumer.

---
 rtl/sram_stream_fifo.sv | 131 +++++++++++++
 tb/tb_sram_stream_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_fifo.sv
// sram_stream_fifo: valid/ready stream FIFO backed by a single-port SRAM
// macro (32x64 ra1shd family). It arbitrates the single port between
// writes and reads each cycle, with reads taking priority. A 2-entry output
// buffer hides the macro's 1-cycle read latency and its undefined Q during
// write cycles.
module sram_stream_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [ADDR_W+1:0] level,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    output logic              sram_CEN,
    output logic              sram_WEN,
    output logic              sram_OEN,
    input  logic [DATA_W-1:0] sram_Q
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W + 1)'(DEPTH);

    // Control state (reset)
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              rd_pend;
    logic              ob_head;
    logic [1:0]        ob_cnt;

    // Data state (not reset)
    logic [DATA_W-1:0] ob [0:1];
    logic [ADDR_W-1:0] a_hold;
    logic [DATA_W-1:0] d_hold;

    // Per-cycle decisions
    logic [2:0] ob_need;
    logic       rd_sel;
    logic       wr_sel;
    logic       pop;
    logic       cap_slot;

    // Outstanding output-buffer demand: occupied slots plus the read in flight.
    assign ob_need  = {1'b0, ob_cnt} + {2'b00, rd_pend};

    // Reads win the port whenever the buffer has room for the result; the
    // decision depends only on registered state, so m_tready and s_tvalid
    // never combine into rd_sel or s_tready.
    assign rd_sel   = (mem_cnt != '0) && (ob_need < 3'd2);
    assign s_tready = !rd_sel && (mem_cnt != MEM_FULL);
    assign wr_sel   = s_tvalid && s_tready;

    // Macro drive; address and write data hold their last values when idle.
    assign sram_A   = rd_sel ? rd_ptr : (wr_sel ? wr_ptr : a_hold);
    assign sram_D   = wr_sel ? s_tdata : d_hold;
    assign sram_CEN = !(rd_sel || wr_sel);
    assign sram_WEN = !wr_sel;
    assign sram_OEN = 1'b0;

    // Output side: head of the 2-entry buffer.
    assign m_tvalid = (ob_cnt != 2'd0);
    assign m_tdata  = ob[ob_head];
    assign pop      = m_tvalid && m_tready;
    assign cap_slot = ob_head ^ ob_cnt[0];

    // The read in flight is counted so level stays put on mem->ob transfers.
    assign level    = (ADDR_W + 2)'(mem_cnt) + (ADDR_W + 2)'(rd_pend)
                    + (ADDR_W + 2)'(ob_cnt);

    // Port stage: SRAM pointers, word count and the read-in-flight flag.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_sel;
            if (rd_sel) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (wr_sel) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            case ({wr_sel, rd_sel})
                2'b10:   mem_cnt <= mem_cnt + (ADDR_W + 1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (ADDR_W + 1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Capture stage: output buffer head and occupancy.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ob_head <= 1'b0;
            ob_cnt  <= 2'd0;
        end else begin
            if (pop) begin
                ob_head <= ~ob_head;
            end
            case ({rd_pend, pop})
                2'b10:   ob_cnt <= ob_cnt + 2'd1;
                2'b01:   ob_cnt <= ob_cnt - 2'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

    // Data path: Q is sampled only when a read was issued on the prior
    // edge, so write-cycle X on Q never enters the buffer.
    always_ff @(posedge axis_clk) begin
        if (rd_pend) begin
            ob[cap_slot] <= sram_Q;
        end
        if (!sram_CEN) begin
            a_hold <= sram_A;
        end
        if (wr_sel) begin
            d_hold <= s_tdata;
        end
    end

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Directed testbench for sram_stream_fifo with a behavioural model of the
// single-port SRAM macro (Q undefined after a write, data one cycle after a read).
module tb_sram_stream_fifo;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [ADDR_W+1:0] level;
    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_D;
    logic              sram_CEN;
    logic              sram_WEN;
    logic              sram_OEN;
    logic [DATA_W-1:0] sram_Q;

    logic [DATA_W-1:0] sram_mem [0:(2**ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    sram_stream_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .level      (level),
        .sram_A     (sram_A),
        .sram_D     (sram_D),
        .sram_CEN   (sram_CEN),
        .sram_WEN   (sram_WEN),
        .sram_OEN   (sram_OEN),
        .sram_Q     (sram_Q)
    );

    always #5 clk = ~clk;

    // SRAM macro model
    always @(posedge clk) begin
        if (!sram_CEN) begin
            if (!sram_WEN) begin
                sram_mem[sram_A] <= sram_D;
                sram_Q           <= 'x;
            end else begin
                sram_Q <= sram_mem[sram_A];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        s_tvalid = 1'b1;
        s_tdata  = 64'h1111;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL rst_pre_level: got %0d expected 1", level); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_checks++; if (sram_CEN !== 1'b1) begin n_fail++; $display("FAIL rst_cen: got %b expected 1", sram_CEN); end
        n_checks++; if (sram_WEN !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b expected 1", sram_WEN); end
        n_checks++; if (sram_OEN !== 1'b0) begin n_fail++; $display("FAIL rst_oen: got %b expected 0", sram_OEN); end
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_s_tready: got %b expected 1", s_tready); end
        step();
        #2;
        rst_n = 1'b1;
        step();
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_s_tready: got %b expected 1", s_tready); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL rst_rel_level: got %0d expected 0", level); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_m_tvalid: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_single();
        s_tdata  = 64'hDEADBEEF_00000001;
        s_tvalid = 1'b1;
        m_tready = 1'b1;
        #1;
        n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL single_s_tready: got %b expected 1", s_tready); end
        n_checks++; if ({sram_CEN, sram_WEN} !== 2'b00) begin n_fail++; $display("FAIL single_wr_drive: got %b expected 00", {sram_CEN, sram_WEN}); end
        step();
        s_tvalid = 1'b0;
        #1;
        n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL single_level_e0: got %0d expected 1", level); end
        n_checks++; if ({sram_CEN, sram_WEN} !== 2'b01) begin n_fail++; $display("FAIL single_rd_drive: got %b expected 01", {sram_CEN, sram_WEN}); end
        n_checks++; if (sram_A !== 5'd0) begin n_fail++; $display("FAIL single_rd_addr: got %0d expected 0", sram_A); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_vld_e0: got %b expected 0", m_tvalid); end
        step();
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_vld_e1: got %b expected 0", m_tvalid); end
        n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL single_level_e1: got %0d expected 1", level); end
        step();
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_vld_e2: got %b expected 1", m_tvalid); end
        n_checks++; if (m_tdata !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef00000001", m_tdata); end
        n_checks++; if (level !== 7'd1) begin n_fail++; $display("FAIL single_level_e2: got %0d expected 1", level); end
        step();
        m_tready = 1'b0;
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_vld_pop: got %b expected 0", m_tvalid); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL single_level_pop: got %0d expected 0", level); end
    endtask

    task automatic test_fill();
        int  idx;
        int  acc_cnt;
        int  exp;
        int  cyc;
        logic acc;
        m_tready = 1'b0;
        idx      = 0;
        acc_cnt  = 0;
        for (int c = 0; c < 120; c++) begin
            s_tvalid = (idx <= 40);
            s_tdata  = 64'(idx);
            #1;
            acc = s_tvalid && s_tready;
            step();
            if (acc) begin
                idx++;
                acc_cnt++;
            end
        end
        s_tvalid = 1'b0;
        #1;
        n_checks++; if (acc_cnt !== 34) begin n_fail++; $display("FAIL fill_accepted: got %0d expected 34", acc_cnt); end
        n_checks++; if (level !== 7'd34) begin n_fail++; $display("FAIL fill_level: got %0d expected 34", level); end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL fill_s_tready: got %b expected 0", s_tready); end
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL fill_m_tvalid: got %b expected 1", m_tvalid); end
        m_tready = 1'b1;
        exp = 0;
        cyc = 0;
        while (exp < 34 && cyc < 200) begin
            #1;
            if (m_tvalid) begin
                n_checks++; if (m_tdata !== 64'(exp)) begin n_fail++; $display("FAIL fill_drain_data: got %0d expected %0d", m_tdata, exp); end
                exp++;
            end
            step();
            cyc++;
        end
        m_tready = 1'b0;
        n_checks++; if (exp !== 34) begin n_fail++; $display("FAIL fill_drain_count: got %0d expected 34", exp); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL fill_drain_level: got %0d expected 0", level); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL fill_drain_vld: got %b expected 0", m_tvalid); end
    endtask

    task automatic test_wrap();
        int send;
        int recv;
        int cyc;
        int bad;
        int last_rd;
        logic saw_wrap;
        logic acc_in;
        logic acc_out;
        send     = 0;
        recv     = 0;
        cyc      = 0;
        bad      = 0;
        last_rd  = -1;
        saw_wrap = 1'b0;
        while (recv < 100 && cyc < 3000) begin
            s_tvalid = (send < 100) && ($urandom_range(0, 1) == 1);
            s_tdata  = 64'(1000 + send);
            m_tready = ($urandom_range(0, 1) == 1);
            #1;
            if (!sram_CEN && !sram_WEN && !(s_tvalid && s_tready)) bad++;
            if (!sram_CEN && sram_WEN) begin
                if (s_tready) bad++;
                if (last_rd == 31 && sram_A == 5'd0) saw_wrap = 1'b1;
                last_rd = int'(sram_A);
            end
            acc_in  = s_tvalid && s_tready;
            acc_out = m_tvalid && m_tready;
            if (acc_out) begin
                n_checks++; if (m_tdata !== 64'(1000 + recv)) begin n_fail++; $display("FAIL wrap_data: got %0d expected %0d", m_tdata, 1000 + recv); end
                recv++;
            end
            if (acc_in) send++;
            step();
            cyc++;
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        #1;
        n_checks++; if (recv !== 100) begin n_fail++; $display("FAIL wrap_count: got %0d expected 100", recv); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_port_conflict: got %0d expected 0", bad); end
        n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_addr_31_to_0: got %b expected 1", saw_wrap); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL wrap_level: got %0d expected 0", level); end
    endtask

    task automatic test_stream();
        int sent;
        int recv;
        int pops_win;
        int xbad;
        int cyc;
        logic acc_in;
        sent     = 0;
        recv     = 0;
        pops_win = 0;
        xbad     = 0;
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL stream_pre_level: got %0d expected 0", level); end
        for (int c = 0; c < 200; c++) begin
            s_tvalid = 1'b1;
            s_tdata  = 64'(5000 + sent);
            m_tready = 1'b1;
            #1;
            acc_in = s_tready;
            if (m_tvalid) begin
                if ($isunknown(m_tdata)) xbad++;
                n_checks++; if (m_tdata !== 64'(5000 + recv)) begin n_fail++; $display("FAIL stream_data: got %0d expected %0d", m_tdata, 5000 + recv); end
                recv++;
                if (c >= 20) pops_win++;
            end
            if (acc_in) sent++;
            step();
        end
        s_tvalid = 1'b0;
        n_checks++; if (pops_win !== 90) begin n_fail++; $display("FAIL stream_rate: got %0d expected 90", pops_win); end
        n_checks++; if (xbad !== 0) begin n_fail++; $display("FAIL stream_x_data: got %0d expected 0", xbad); end
        cyc = 0;
        while (recv < sent && cyc < 100) begin
            #1;
            if (m_tvalid) begin
                n_checks++; if (m_tdata !== 64'(5000 + recv)) begin n_fail++; $display("FAIL stream_tail_data: got %0d expected %0d", m_tdata, 5000 + recv); end
                recv++;
            end
            step();
            cyc++;
        end
        m_tready = 1'b0;
        n_checks++; if (recv !== sent) begin n_fail++; $display("FAIL stream_tail_count: got %0d expected %0d", recv, sent); end
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL stream_tail_level: got %0d expected 0", level); end
    endtask

    task automatic test_rd_reset();
        int bad;
        bad      = 0;
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        s_tvalid = 1'b0;
        #1;
        n_checks++; if ({sram_CEN, sram_WEN} !== 2'b01) begin n_fail++; $display("FAIL rdrst_read_issue: got %b expected 01", {sram_CEN, sram_WEN}); end
        step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL rdrst_level: got %0d expected 0", level); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rdrst_vld: got %b expected 0", m_tvalid); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m_tvalid !== 1'b0 || level !== 7'd0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rdrst_no_capture: got %0d expected 0", bad); end
        s_tvalid = 1'b1;
        s_tdata  = 64'hA5A5_A5A5_0000_0002;
        m_tready = 1'b1;
        step();
        s_tvalid = 1'b0;
        step();
        step();
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rdrst_new_vld: got %b expected 1", m_tvalid); end
        n_checks++; if (m_tdata !== 64'hA5A5_A5A5_0000_0002) begin n_fail++; $display("FAIL rdrst_new_data: got %h expected a5a5a5a500000002", m_tdata); end
        step();
        m_tready = 1'b0;
        n_checks++; if (level !== 7'd0) begin n_fail++; $display("FAIL rdrst_final_level: got %0d expected 0", level); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_stream();
        test_rd_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
